risc16_mem_responder: RTL and testbench

// - Memory-side responder for the RISC16 pipelined core's instruction and data ports.
// - Serves instruction fetch (iaddr/idin) and load/store (daddr/doe/dwe/ddout/ddin) from a unified word array.
// - Contains a boot loader FSM that streams a program in from a host while holding the core in reset, then releases it.
// - Decodes a small MMIO window: cycle counter, GPIO out, GPIO in.

---
 rtl/risc16_pkg.sv | 15 +
 rtl/risc16_mem_array.sv | 27 ++
 rtl/risc16_mem_responder.sv | 155 +++++++++++++++
 tb/tb_risc16_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared types and MMIO offsets for the RISC16 memory responder.
package risc16_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Byte offsets inside the 16-byte MMIO window
    localparam logic [3:0] MMIO_CYC = 4'h0;
    localparam logic [3:0] MMIO_GPO = 4'h2;
    localparam logic [3:0] MMIO_GPI = 4'h4;

endpackage

// File: rtl/risc16_mem_array.sv
// Unified word array: two combinational read ports, one synchronous write port.
// Contents are deliberately not reset so a program survives rst_ni.
module risc16_mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [15:0]       rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [15:0]       rdata_b_o
);

    logic [15:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/risc16_mem_responder.sv
// Memory-side responder for the RISC16 core: boot loader FSM, unified array,
// and a small MMIO window (cycle counter, GPIO out, GPIO in).
module risc16_mem_responder
    import risc16_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          RST_HOLD  = 4,
    parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] iaddr_i,
    input  logic        ioe_i,
    output logic [15:0] idin_o,
    input  logic [15:0] daddr_i,
    input  logic [15:0] ddout_i,
    input  logic        doe_i,
    input  logic        dwe_i,
    output logic [15:0] ddin_o,
    input  logic        ld_valid_i,
    input  logic [15:0] ld_data_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    input  logic        reboot_i,
    output logic        cpu_rst_o,
    input  logic [15:0] gpio_in_i,
    output logic [15:0] gpio_out_o
);

    localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
    localparam logic [3:0]        HOLD_INIT = 4'(RST_HOLD - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        hold_q, hold_d;
    logic [15:0]       cyc_q, cyc_d;
    logic [15:0]       gpo_q, gpo_d;
    logic              cpu_rst_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_irdata;
    logic [15:0]       mem_drdata;
    logic [15:0]       mmio_rdata;
    logic              mmio_sel;
    logic [3:0]        d_off;
    logic              ld_ready;
    logic              unused_addr_bits;

    assign mmio_sel = (daddr_i[15:4] == MMIO_BASE[15:4]);
    assign d_off    = {daddr_i[3:1], 1'b0};
    assign unused_addr_bits = ^{iaddr_i[15:ADDR_W+1], iaddr_i[0], daddr_i[0]};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        cyc_d     = cyc_q;
        gpo_d     = gpo_q;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = daddr_i[ADDR_W:1];
        mem_wdata = ddout_i;

        case (state_q)
            ST_LOAD: begin
                ld_ready  = 1'b1;
                cyc_d     = 16'h0000;
                mem_waddr = ptr_q;
                mem_wdata = ld_data_i;
                if (ld_valid_i) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    // A full array ends the image even without ld_last
                    if (ld_last_i || (ptr_q == PTR_MAX)) begin
                        state_d = ST_HOLD;
                        ptr_d   = '0;
                        hold_d  = HOLD_INIT;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            ST_RUN: begin
                mem_we = dwe_i && !mmio_sel;
                if (dwe_i && mmio_sel && (d_off == MMIO_GPO)) begin
                    gpo_d = ddout_i;
                end
                cyc_d = cyc_q + 16'd1;
                if (reboot_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cyc_d   = 16'h0000;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_LOAD;
            ptr_q     <= '0;
            hold_q    <= 4'd0;
            cyc_q     <= 16'h0000;
            gpo_q     <= 16'h0000;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            cyc_q     <= cyc_d;
            gpo_q     <= gpo_d;
            cpu_rst_q <= (state_d != ST_RUN);
        end
    end

    risc16_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i     (clk_i),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .raddr_a_i (iaddr_i[ADDR_W:1]),
        .rdata_a_o (mem_irdata),
        .raddr_b_i (daddr_i[ADDR_W:1]),
        .rdata_b_o (mem_drdata)
    );

    always_comb begin
        case (d_off)
            MMIO_CYC: mmio_rdata = cyc_q;
            MMIO_GPO: mmio_rdata = gpo_q;
            MMIO_GPI: mmio_rdata = gpio_in_i;
            default:  mmio_rdata = 16'h0000;
        endcase
    end

    // Instruction port never decodes MMIO; it always reads the array
    assign idin_o     = ioe_i ? mem_irdata : 16'h0000;
    assign ddin_o     = doe_i ? (mmio_sel ? mmio_rdata : mem_drdata) : 16'h0000;
    assign ld_ready_o = ld_ready;
    assign cpu_rst_o  = cpu_rst_q;
    assign gpio_out_o = gpo_q;

endmodule

// File: tb/tb_risc16_mem_responder.sv
// Directed scoreboard bench for risc16_mem_responder.
module tb_risc16_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] iaddr;
    logic        ioe;
    logic [15:0] idin;
    logic [15:0] daddr;
    logic [15:0] ddout;
    logic        doe;
    logic        dwe;
    logic [15:0] ddin;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        reboot;
    logic        cpu_rst;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;

    logic [15:0] exp_q[$];
    int          total;
    int          bad;
    logic        run_mdl;
    logic [15:0] cyc_mdl;

    risc16_mem_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .iaddr_i    (iaddr),
        .ioe_i      (ioe),
        .idin_o     (idin),
        .daddr_i    (daddr),
        .ddout_i    (ddout),
        .doe_i      (doe),
        .dwe_i      (dwe),
        .ddin_o     (ddin),
        .ld_valid_i (ld_valid),
        .ld_data_i  (ld_data),
        .ld_last_i  (ld_last),
        .ld_ready_o (ld_ready),
        .reboot_i   (reboot),
        .cpu_rst_o  (cpu_rst),
        .gpio_in_i  (gpio_in),
        .gpio_out_o (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // One clock; the cycle-counter model advances on each RUN edge
    task automatic step();
        @(posedge clk);
        if (run_mdl) begin
            if (reboot) begin
                run_mdl = 1'b0;
                cyc_mdl = 16'h0000;
            end else begin
                cyc_mdl = cyc_mdl + 16'd1;
            end
        end
        #1;
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu_rst === 1'b1 && n < 20) begin
            n++;
            step();
        end
        push(16'd4);
        chk("hold_cycles", 16'(n));
        if (cpu_rst === 1'b0) begin
            run_mdl = 1'b1;
            cyc_mdl = 16'h0000;
        end
    endtask

    task automatic iread(input string tag, input logic [15:0] a, input logic [15:0] e);
        ioe   = 1'b1;
        iaddr = a;
        push(e);
        #1;
        chk(tag, idin);
    endtask

    task automatic dread(input string tag, input logic [15:0] a, input logic [15:0] e);
        doe   = 1'b1;
        daddr = a;
        push(e);
        #1;
        chk(tag, ddin);
    endtask

    initial begin
        total = 0; bad = 0; run_mdl = 1'b0; cyc_mdl = 16'h0000;
        rst_n = 1'b0; iaddr = '0; ioe = 1'b0; daddr = '0; ddout = '0;
        doe = 1'b0; dwe = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        reboot = 1'b0; gpio_in = '0;

        #12;
        push(16'd1); chk("rst_cpu_rst", {15'd0, cpu_rst});
        push(16'd1); chk("rst_ld_ready", {15'd0, ld_ready});
        push(16'h0000); chk("rst_gpio_out", gpio_out);
        step();
        rst_n = 1'b1;
        step();

        load_word(16'h8001, 1'b0);
        load_word(16'h1234, 1'b0);
        load_word(16'hABCD, 1'b1);
        push(16'd0); chk("ld_ready_after_last", {15'd0, ld_ready});
        wait_run();
        iread("fetch_0002", 16'h0002, 16'h1234);
        iread("fetch_0004", 16'h0004, 16'hABCD);
        ioe = 1'b0; push(16'h0000); #1; chk("ioe_low", idin);

        // Seed 0x0010, then overwrite while reading it on both ports
        dwe = 1'b1; daddr = 16'h0010; ddout = 16'h1111;
        step();
        ddout = 16'h5A5A; doe = 1'b1; ioe = 1'b1; iaddr = 16'h0010;
        push(16'h1111); push(16'h1111); #1;
        chk("rdw_ddin_old", ddin);
        chk("rdw_idin_old", idin);
        step();
        dwe = 1'b0;
        dread("load_after_store", 16'h0010, 16'h5A5A);
        doe = 1'b0; push(16'h0000); #1; chk("doe_low", ddin);

        dwe = 1'b1; daddr = 16'hFFF2; ddout = 16'h00FF;
        step();
        dwe = 1'b0;
        push(16'h00FF); chk("gpio_out_write", gpio_out);
        dread("mmio_gpo_read", 16'hFFF2, 16'h00FF);
        gpio_in = 16'hC3C3;
        dread("mmio_gpi_read", 16'hFFF4, 16'hC3C3);
        dread("mmio_unused_off", 16'hFFF8, 16'h0000);
        dread("cycle_cnt_a", 16'hFFF0, cyc_mdl);
        step();
        dread("cycle_cnt_b", 16'hFFF0, cyc_mdl);
        doe = 1'b0;

        // Reboot with a simultaneous store that must still land
        reboot = 1'b1; dwe = 1'b1; daddr = 16'h0020; ddout = 16'h2222;
        step();
        reboot = 1'b0; dwe = 1'b0;
        push(16'd1); chk("reboot_cpu_rst", {15'd0, cpu_rst});
        push(16'd1); chk("reboot_ld_ready", {15'd0, ld_ready});
        dread("reboot_cycle_cnt", 16'hFFF0, 16'h0000);
        doe = 1'b0;
        iread("store_with_reboot", 16'h0020, 16'h2222);
        dwe = 1'b1; daddr = 16'h0020; ddout = 16'hDEAD;
        step();
        dwe = 1'b0;
        iread("core_store_in_load", 16'h0020, 16'h2222);

        load_word(16'hAAAA, 1'b0);
        load_word(16'hBBBB, 1'b0);
        rst_n = 1'b0;
        #1;
        push(16'd1); chk("midload_rst_cpu_rst", {15'd0, cpu_rst});
        push(16'd1); chk("midload_rst_ld_ready", {15'd0, ld_ready});
        push(16'h0000); chk("midload_rst_gpio", gpio_out);
        iread("kept_word0", 16'h0000, 16'hAAAA);
        iread("kept_word1", 16'h0002, 16'hBBBB);
        step();
        rst_n = 1'b1;
        step();
        load_word(16'hCCCC, 1'b1);
        iread("ptr_restart_w0", 16'h0000, 16'hCCCC);
        iread("ptr_restart_w1", 16'h0002, 16'hBBBB);
        wait_run();

        reboot = 1'b1;
        step();
        reboot = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            if (i == 1023) begin
                push(16'd1); chk("fill_ready_before_last", {15'd0, ld_ready});
            end
            load_word(16'(i) ^ 16'h5A00, 1'b0);
        end
        push(16'd0); chk("fill_hold_entered", {15'd0, ld_ready});
        iread("fill_last_word", 16'h07FE, 16'h5A00 ^ 16'd1023);
        iread("fill_alias_word0", 16'h0800, 16'h5A00);
        iread("fill_alias_word1", 16'h0802, 16'h5A01);
        wait_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
